trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed (32-bit datapath, 16-bit counter).
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 instr_valid  in  1  the retiring instruction's flags and PC below are valid this cycle.
REQ-005 pc  in  32  PC of the retiring instruction.
REQ-006 fetch_misaligned, illegal_instr, is_ebreak, load_misaligned, store_misaligned, is_ecall, is_mret  in  1 each  decode/execute flags.
REQ-007 mtvec, mepc  in  32  from the CSR file.
REQ-008 mie  in  1  mstatus.MIE from the CSR file.
REQ-009 ext_irq  in  1  machine external interrupt request, synchronous to clk.
REQ-010 kill  out  1  suppresses writeback/memory side effects of the current instruction.
REQ-011 stall  out  1  freezes the PC and fetch.
REQ-012 trap_enter, trap_exit  out  1 each  one-cycle pulses to the CSR file.
REQ-013 trap_pc, exception_code  out  32 each  mepc/mcause values for the CSR file.
REQ-014 pc_redirect  out  1  load redirect_pc into the PC this cycle.
REQ-015 redirect_pc  out  32  redirect target.
REQ-016 trap_count  out  16  number of traps taken.

Function
REQ-017 The FSM SHALL have four states: IDLE, ENTER, EXIT, REDIR.
REQ-018 In IDLE with instr_valid=1, the cause SHALL be selected by priority: interrupt > fetch_misaligned (0) > illegal_instr (2) > is_ebreak (3) > load_misaligned (4) > store_misaligned (6) > is_ecall (11).
REQ-019 When a cause is selected, the block SHALL assert combinational kill, latch trap_pc=pc and exception_code=cause, and move to ENTER.
REQ-020 In IDLE with instr_valid=1, is_mret=1 and no cause, the block SHALL assert kill and move to EXIT.
REQ-021 If is_mret is asserted together with an exception, the exception SHALL win.
REQ-022 ENTER SHALL assert trap_enter for exactly one cycle.
REQ-023 ENTER SHALL latch the target: {mtvec[31:2],2'b00}; if mtvec[1:0]=01 and the trap is an interrupt, the target SHALL be that base + 4*exception_code[30:0].
REQ-024 ENTER SHALL increment trap_count (wraps 0xFFFF->0) and then go to REDIR.
REQ-025 EXIT SHALL assert trap_exit for one cycle, latch target={mepc[31:2],2'b00}, then go to REDIR.
REQ-026 REDIR SHALL assert pc_redirect with redirect_pc=target for one cycle, then return to IDLE.
REQ-027 stall SHALL equal (state != IDLE); instr_valid SHALL be ignored outside IDLE.
REQ-028 trap_pc and exception_code SHALL hold their values until the next trap.
REQ-029 Latency: a trap SHALL take 3 cycles from the detection edge to the first fetch at the target.
REQ-030 trap_enter and trap_exit SHALL never be asserted in the same cycle.

Reset
REQ-031 On reset, state SHALL be IDLE and all outputs 0: stall, kill, trap_enter, trap_exit, pc_redirect, trap_pc, exception_code, redirect_pc, trap_count.
REQ-032 On reset, the internal target and the irq_pending/ext_irq_q registers SHALL be 0.
REQ-033 A reset asserted mid-sequence SHALL abort the sequence with no further trap_enter, trap_exit or pc_redirect pulse.

Configuration
REQ-034 Macro TRAP_CTRL_IRQ_EN SHALL control interrupt support.
REQ-035 With TRAP_CTRL_IRQ_EN defined, a rising edge of ext_irq (versus registered ext_irq_q) SHALL set sticky irq_pending.
REQ-036 irq_pending SHALL be taken in IDLE when instr_valid=1 and mie=1, with cause 0x8000000B and trap_pc=pc; taking it SHALL clear irq_pending.
REQ-037 An edge arriving while not in IDLE SHALL stay pending and not be lost.
REQ-038 Without TRAP_CTRL_IRQ_EN, ext_irq SHALL be ignored, no pending register SHALL exist, and vectored offset logic SHALL be absent (target is always the base).

Verification
REQ-039 ecall at pc=0x100, mtvec=0x200: kill in cycle N; trap_enter, code=11, trap_pc=0x100 in N+1; pc_redirect to 0x200 in N+2; trap_count=1.
REQ-040 illegal_instr=1 and is_ecall=1 together: code=2.
REQ-041 is_mret=1 with mepc=0x104: trap_exit in N+1, redirect 0x104 in N+2, trap_enter stays 0.
REQ-042 (IRQ_EN) ext_irq edge, mie=1, mtvec=0x301, instr at pc=0x40: code=0x8000000B, trap_pc=0x40, redirect 0x32C.
REQ-043 (IRQ_EN) ext_irq edge with mie=0: no trap; set mie=1: trap on the next valid instruction.
REQ-044 reset during ENTER: no pc_redirect, all outputs 0; trap_count wraps from 0xFFFF to 0 on the next trap.

Source files
------------

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry/exit sequencer (optional interrupts via TRAP_CTRL_IRQ_EN)
module trap_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] pc,
    input  logic        fetch_misaligned,
    input  logic        illegal_instr,
    input  logic        is_ebreak,
    input  logic        load_misaligned,
    input  logic        store_misaligned,
    input  logic        is_ecall,
    input  logic        is_mret,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        mie,
    input  logic        ext_irq,
    output logic        kill,
    output logic        stall,
    output logic        trap_enter,
    output logic        trap_exit,
    output logic [31:0] trap_pc,
    output logic [31:0] exception_code,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [15:0] trap_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        EXIT  = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t      state_q;
    logic        trap_enter_q;
    logic        trap_exit_q;
    logic        pc_redirect_q;
    logic [31:0] trap_pc_q;
    logic [31:0] exception_code_q;
    logic [31:0] target_q;
    logic [15:0] trap_count_q;

    logic        irq_take;
    logic        exc_valid;
    logic [31:0] exc_code;
    logic        trap_req;
    logic        mret_req;
    logic [31:0] enter_target;

`ifdef TRAP_CTRL_IRQ_EN
    logic ext_irq_q;
    logic irq_pending_q;

    assign irq_take = irq_pending_q & mie;

    // Sticky pending bit: set on a rising edge of ext_irq, cleared when the interrupt is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_irq_q     <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            ext_irq_q <= ext_irq;
            if (ext_irq && !ext_irq_q) begin
                irq_pending_q <= 1'b1;
            end else if (trap_req && irq_take) begin
                irq_pending_q <= 1'b0;
            end
        end
    end
`else
    assign irq_take = 1'b0;
`endif

    // Cause selection: interrupt first, then synchronous exceptions by fixed priority.
    always_comb begin
        exc_valid = 1'b0;
        exc_code  = 32'd0;
        if (irq_take) begin
            exc_valid = 1'b1;
            exc_code  = 32'h8000_000B;
        end else if (fetch_misaligned) begin
            exc_valid = 1'b1;
            exc_code  = 32'd0;
        end else if (illegal_instr) begin
            exc_valid = 1'b1;
            exc_code  = 32'd2;
        end else if (is_ebreak) begin
            exc_valid = 1'b1;
            exc_code  = 32'd3;
        end else if (load_misaligned) begin
            exc_valid = 1'b1;
            exc_code  = 32'd4;
        end else if (store_misaligned) begin
            exc_valid = 1'b1;
            exc_code  = 32'd6;
        end else if (is_ecall) begin
            exc_valid = 1'b1;
            exc_code  = 32'd11;
        end
    end

    assign trap_req = (state_q == IDLE) && instr_valid && exc_valid;
    assign mret_req = (state_q == IDLE) && instr_valid && is_mret && !exc_valid;

    // Trap vector: direct base, or base + 4*cause for vectored interrupts.
    always_comb begin
        enter_target = {mtvec[31:2], 2'b00};
`ifdef TRAP_CTRL_IRQ_EN
        if ((mtvec[1:0] == 2'b01) && exception_code_q[31]) begin
            enter_target = {mtvec[31:2], 2'b00} + {exception_code_q[29:0], 2'b00};
        end
`endif
    end

    // Sequencer: IDLE -> ENTER/EXIT -> REDIR -> IDLE with one-cycle registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            trap_enter_q     <= 1'b0;
            trap_exit_q      <= 1'b0;
            pc_redirect_q    <= 1'b0;
            trap_pc_q        <= 32'd0;
            exception_code_q <= 32'd0;
            target_q         <= 32'd0;
            trap_count_q     <= 16'd0;
        end else begin
            trap_enter_q  <= 1'b0;
            trap_exit_q   <= 1'b0;
            pc_redirect_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trap_req) begin
                        state_q          <= ENTER;
                        trap_enter_q     <= 1'b1;
                        trap_pc_q        <= pc;
                        exception_code_q <= exc_code;
                    end else if (mret_req) begin
                        state_q     <= EXIT;
                        trap_exit_q <= 1'b1;
                    end
                end
                ENTER: begin
                    target_q      <= enter_target;
                    trap_count_q  <= trap_count_q + 16'd1;
                    pc_redirect_q <= 1'b1;
                    state_q       <= REDIR;
                end
                EXIT: begin
                    target_q      <= {mepc[31:2], 2'b00};
                    pc_redirect_q <= 1'b1;
                    state_q       <= REDIR;
                end
                REDIR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign kill           = trap_req | mret_req;
    assign stall          = (state_q != IDLE);
    assign trap_enter     = trap_enter_q;
    assign trap_exit      = trap_exit_q;
    assign pc_redirect    = pc_redirect_q;
    assign trap_pc        = trap_pc_q;
    assign exception_code = exception_code_q;
    assign redirect_pc    = target_q;
    assign trap_count     = trap_count_q;

    // Bits that are intentionally not consumed in every build.
    logic unused_bits;
`ifdef TRAP_CTRL_IRQ_EN
    assign unused_bits = ^{mepc[1:0], exception_code_q[30]};
`else
    assign unused_bits = ^{mepc[1:0], mtvec[1:0], ext_irq, mie, exception_code_q[31:30]};
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] pc;
    logic        fetch_misaligned, illegal_instr, is_ebreak, load_misaligned;
    logic        store_misaligned, is_ecall, is_mret;
    logic [31:0] mtvec, mepc;
    logic        mie, ext_irq;
    logic        kill, stall, trap_enter, trap_exit, pc_redirect;
    logic [31:0] trap_pc, exception_code, redirect_pc;
    logic [15:0] trap_count;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] F_FETCH = 7'b1000000;
    localparam logic [6:0] F_ILL   = 7'b0100000;
    localparam logic [6:0] F_LOAD  = 7'b0001000;
    localparam logic [6:0] F_STORE = 7'b0000100;
    localparam logic [6:0] F_ECALL = 7'b0000010;
    localparam logic [6:0] F_MRET  = 7'b0000001;

    trap_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid      (instr_valid),
        .pc               (pc),
        .fetch_misaligned (fetch_misaligned),
        .illegal_instr    (illegal_instr),
        .is_ebreak        (is_ebreak),
        .load_misaligned  (load_misaligned),
        .store_misaligned (store_misaligned),
        .is_ecall         (is_ecall),
        .is_mret          (is_mret),
        .mtvec            (mtvec),
        .mepc             (mepc),
        .mie              (mie),
        .ext_irq          (ext_irq),
        .kill             (kill),
        .stall            (stall),
        .trap_enter       (trap_enter),
        .trap_exit        (trap_exit),
        .trap_pc          (trap_pc),
        .exception_code   (exception_code),
        .pc_redirect      (pc_redirect),
        .redirect_pc      (redirect_pc),
        .trap_count       (trap_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] p, input logic [6:0] f);
        instr_valid = 1'b1;
        pc          = p;
        {fetch_misaligned, illegal_instr, is_ebreak, load_misaligned,
         store_misaligned, is_ecall, is_mret} = f;
    endtask

    task automatic idle_in;
        issue(32'd0, 7'd0);
        instr_valid = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        mtvec   = 32'h200;
        mepc    = 32'd0;
        mie     = 1'b0;
        ext_irq = 1'b0;
        idle_in();
        tick();
        tick();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_kill", {31'd0, kill}, 32'd0);
        check("rst_redir", {31'd0, pc_redirect}, 32'd0);
        check("rst_code", exception_code, 32'd0);
        check("rst_count", {16'd0, trap_count}, 32'd0);
        reset = 1'b0;
        tick();

        // ecall at 0x100, mtvec 0x200
        issue(32'h100, F_ECALL);
        #1;
        check("ecall_kill", {31'd0, kill}, 32'd1);
        tick();
        idle_in();
        #1;
        check("ecall_enter", {31'd0, trap_enter}, 32'd1);
        check("ecall_code", exception_code, 32'd11);
        check("ecall_tpc", trap_pc, 32'h100);
        check("ecall_stall", {31'd0, stall}, 32'd1);
        tick();
        check("ecall_redir", {31'd0, pc_redirect}, 32'd1);
        check("ecall_rpc", redirect_pc, 32'h200);
        check("ecall_enter_off", {31'd0, trap_enter}, 32'd0);
        check("ecall_count", {16'd0, trap_count}, 32'd1);
        tick();
        check("ecall_done", {30'd0, stall, pc_redirect}, 32'd0);

        // illegal + ecall -> code 2; valid held through ENTER/REDIR must be ignored
        mtvec = 32'h400;
        issue(32'h120, F_ILL | F_ECALL);
        tick();
        #1;
        check("ill_code", exception_code, 32'd2);
        check("ill_nokill_busy", {31'd0, kill}, 32'd0);
        tick();
        check("ill_rpc", redirect_pc, 32'h400);
        tick();
        idle_in();
        #1;
        check("ill_count", {16'd0, trap_count}, 32'd2);
        check("ill_idle", {31'd0, stall}, 32'd0);

        // mret with mepc 0x104 (low bits dropped)
        mepc = 32'h107;
        issue(32'h130, F_MRET);
        #1;
        check("mret_kill", {31'd0, kill}, 32'd1);
        tick();
        idle_in();
        #1;
        check("mret_exit", {30'd0, trap_exit, trap_enter}, 32'd2);
        tick();
        check("mret_redir", {31'd0, pc_redirect}, 32'd1);
        check("mret_rpc", redirect_pc, 32'h104);
        check("mret_noenter", {30'd0, trap_exit, trap_enter}, 32'd0);
        check("mret_count", {16'd0, trap_count}, 32'd2);
        tick();

        // mret together with load misalign: exception wins
        issue(32'h140, F_MRET | F_LOAD);
        tick();
        idle_in();
        #1;
        check("mretx_enter", {30'd0, trap_exit, trap_enter}, 32'd1);
        check("mretx_code", exception_code, 32'd4);
        tick();
        tick();

        // priority: fetch misalign over illegal; then store over ecall
        issue(32'h150, F_FETCH | F_ILL);
        tick();
        idle_in();
        #1;
        check("fetch_code", exception_code, 32'd0);
        check("fetch_tpc", trap_pc, 32'h150);
        tick();
        tick();
        issue(32'h160, F_STORE | F_ECALL);
        tick();
        idle_in();
        #1;
        check("store_code", exception_code, 32'd6);
        tick();
        tick();
        check("count5", {16'd0, trap_count}, 32'd5);

        // reset asserted during ENTER aborts the sequence
        issue(32'h180, F_ECALL);
        tick();
        idle_in();
        #1;
        check("abort_enter", {31'd0, trap_enter}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_flags", {27'd0, stall, kill, trap_enter, trap_exit, pc_redirect}, 32'd0);
        check("abort_tpc", trap_pc, 32'd0);
        check("abort_rpc", redirect_pc, 32'd0);
        check("abort_count", {16'd0, trap_count}, 32'd0);
        tick();
        check("abort_noredir1", {31'd0, pc_redirect}, 32'd0);
        reset = 1'b0;
        tick();
        check("abort_noredir2", {30'd0, pc_redirect, stall}, 32'd0);

        // counter wrap 0xFFFF -> 0
        force dut.trap_count_q = 16'hFFFF;
        #1;
        release dut.trap_count_q;
        tick();
        issue(32'h1A0, F_ECALL);
        tick();
        idle_in();
        tick();
        check("wrap_count", {16'd0, trap_count}, 32'd0);
        tick();

`ifdef TRAP_CTRL_IRQ_EN
        // external interrupt, vectored mtvec 0x301
        mtvec   = 32'h301;
        mie     = 1'b1;
        ext_irq = 1'b1;
        tick();
        issue(32'h40, 7'd0);
        #1;
        check("irq_kill", {31'd0, kill}, 32'd1);
        tick();
        idle_in();
        #1;
        check("irq_code", exception_code, 32'h8000_000B);
        check("irq_tpc", trap_pc, 32'h40);
        tick();
        check("irq_rpc", redirect_pc, 32'h32C);
        check("irq_redir", {31'd0, pc_redirect}, 32'd1);
        tick();

        // interrupt masked by mie=0, then taken once enabled
        ext_irq = 1'b0;
        tick();
        ext_irq = 1'b1;
        mie     = 1'b0;
        mtvec   = 32'h300;
        tick();
        issue(32'h50, 7'd0);
        #1;
        check("irqm_nokill", {31'd0, kill}, 32'd0);
        tick();
        check("irqm_notrap", {30'd0, stall, trap_enter}, 32'd0);
        mie = 1'b1;
        #1;
        check("irqm_kill", {31'd0, kill}, 32'd1);
        tick();
        idle_in();
        #1;
        check("irqm_code", exception_code, 32'h8000_000B);
        check("irqm_tpc", trap_pc, 32'h50);
        tick();
        tick();
`else
        // without interrupt support ext_irq has no effect
        mie     = 1'b1;
        ext_irq = 1'b1;
        tick();
        issue(32'h40, 7'd0);
        #1;
        check("noirq_kill", {31'd0, kill}, 32'd0);
        tick();
        idle_in();
        #1;
        check("noirq_enter", {30'd0, stall, trap_enter}, 32'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
